key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Sits between the PS/2 keyboard decoder and the game/setting FSM.
- Converts raw decoder output (key_valid, last_change, make/break) into clean, typed, one-per-press key events, with typematic repeats suppressed.
- Buffers events in a small FIFO behind a valid/ready handshake, so the consumer FSM never misses a press or double-counts one while busy.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe from the decoder: last_change updated
last_change  in  9  scan code; bit 8 = E0 extended prefix
key_pressed  in  1  key_down[last_change] qualified with key_valid: 1 = make, 0 = break
flush  in  1  synchronous clear of pending events (consumer state change)
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts the head this cycle
ev_type  out  2  0 = DIGIT, 1 = SPACE, 2 = BKSP, 3 = unused
ev_digit  out  4  0..9 for DIGIT; 0 otherwise
ev_keypad  out  1  1 if the digit came from the numeric keypad
overflow  out  1  sticky: an event was dropped because the FIFO was full
drop_cnt  out  CNT_W  saturating count of dropped events

Behaviour:
- Reset: rst_n low asynchronously clears all of the following. Outputs 0: ev_valid, ev_type, ev_digit, ev_keypad, overflow, drop_cnt. State cleared: FIFO pointers, pipeline register, held table.
- Classification (combinational on last_change, bit 8 must be 0):
  - Top-row digits: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46 -> DIGIT 0..9, keypad = 0.
  - Keypad digits: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D -> DIGIT 0..9, keypad = 1.
  - 29 -> SPACE; 66 -> BKSP.
  - Any other code, including any code with bit 8 = 1 -> ignored.
  - Index space: 22 classes (20 digit keys, space, backspace).
- Held table: 22-bit register, one bit per class.
  - Make on a class: sets the bit.
  - Break on a class: clears the bit; break never generates an event.
- Press detection: at a clk edge where key_valid=1, key_pressed=1, the class is valid and its held bit=0, the event is captured into the one-entry pipeline register.
  - If the held bit is already 1 (typematic repeat), nothing is captured.
  - The held bit is set on the same edge.
- Write stage: the pipeline register is written into the FIFO on the next edge.
  - Latency: key_valid sampled at edge T -> entry written at T+1 -> ev_valid high after T+1 when the FIFO was empty.
- Handshake: pop happens on an edge where ev_valid and ev_ready are both 1.
  - ev_type, ev_digit and ev_keypad are driven from the FIFO head and hold stable while ev_valid=1 and ev_ready=0.
  - ev_ready while ev_valid=0 has no effect.
- Full FIFO:
  - Push without a simultaneous pop: the event is dropped, overflow is set, drop_cnt increments and saturates at all-ones.
  - Push with a simultaneous pop: both succeed and the count is unchanged.
- Empty FIFO: a push and a write on the same edge are legal; there is no bypass, so ev_valid rises the following cycle.
- Pointers: log2(DEPTH)+1 bits each, wrap naturally. Full = MSBs differ and lower bits equal. Empty = pointers equal.
- flush=1 at an edge:
  - Clears the FIFO pointers, the pipeline register and overflow; ev_valid=0 next cycle.
  - drop_cnt is retained.
  - The held table is retained, because physically held keys must not re-fire.
  - An event being captured or written on the same edge is discarded and is not counted as a drop.
- Events arriving every cycle: the pipeline accepts one per cycle with no stall; back-pressure appears only as FIFO drops.
- Reset mid-operation: everything above is cleared; after release, a key still physically held produces an event on its next make (repeat) code. This is accepted.

Decomposition:
- Shared package:
  - scan-code constants: 20 digit codes, SPACE, BKSP;
  - ev_type encodings DIGIT/SPACE/BKSP;
  - a class-index function scan code -> {valid, class[4:0], type, digit, keypad}.
- One sub-module, key_event_fifo: a generic synchronous FIFO (DEPTH, WIDTH=7, full/empty, no bypass).
- Classification, held table and pipeline register stay in the top.

Test Plan:
1. Reset, then key_valid with 1E make -> ev_valid rises two edges later with ev_type=0, ev_digit=2, ev_keypad=0. ev_ready=1 pops it; ev_valid=0 next cycle.
2. 16 make repeated 5 times (typematic), then 16 break, then 16 make -> exactly 2 DIGIT 1 events; the breaks produce none.
3. ev_ready=0; six distinct makes 45, 69, 29, 66, 3E, 7D with DEPTH=4 -> 4 events queued in order (0, keypad 1, SPACE, BKSP); overflow=1; drop_cnt=2. Draining returns them in that order.
4. FIFO full, ev_ready=1 on the same edge a new make is written -> no drop; count stays 4; head advances.
5. Three events queued, flush=1 in the same cycle as a new make -> ev_valid=0, overflow=0, drop_cnt unchanged. A later repeat make of the held key yields no event; break then make yields one.
6. E0-prefixed 70 (bit 8=1), unlisted code 1C, and rst_n asserted low mid-queue -> no events from the first two; after the rst_n pulse all outputs are 0 and the FIFO is empty.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the key event queue: scan codes, event encodings and
// the scan-code classifier used by the press detector.
package key_event_queue_pkg;

   localparam int unsigned NumClasses = 22;
   localparam int unsigned EventW     = 7;

   typedef enum logic [1:0] {
      EvDigit  = 2'd0,
      EvSpace  = 2'd1,
      EvBksp   = 2'd2,
      EvUnused = 2'd3
   } ev_type_e;

   localparam logic [7:0] ScSpace = 8'h29;
   localparam logic [7:0] ScBksp  = 8'h66;

   // Index i of each table is the digit value i.
   localparam logic [7:0] ScTopRow [10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
   };
   localparam logic [7:0] ScKeypad [10] = '{
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
   };

   localparam logic [4:0] ClsSpace = 5'd20;
   localparam logic [4:0] ClsBksp  = 5'd21;

   typedef struct packed {
      logic [1:0] ev_type;
      logic [3:0] digit;
      logic       keypad;
   } key_event_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
      key_event_t ev;
   } key_class_t;

   // Top-row digits take classes 0..9, keypad digits 10..19.
   function automatic key_class_t classify(input logic [8:0] code);
      key_class_t c;
      c = '0;
      if (!code[8]) begin
         for (int i = 0; i < 10; i++) begin
            if (code[7:0] == ScTopRow[i]) begin
               c.valid      = 1'b1;
               c.idx        = 5'(i);
               c.ev.ev_type = EvDigit;
               c.ev.digit   = 4'(i);
               c.ev.keypad  = 1'b0;
            end
            if (code[7:0] == ScKeypad[i]) begin
               c.valid      = 1'b1;
               c.idx        = 5'(i + 10);
               c.ev.ev_type = EvDigit;
               c.ev.digit   = 4'(i);
               c.ev.keypad  = 1'b1;
            end
         end
         if (code[7:0] == ScSpace) begin
            c.valid      = 1'b1;
            c.idx        = ClsSpace;
            c.ev.ev_type = EvSpace;
         end
         if (code[7:0] == ScBksp) begin
            c.valid      = 1'b1;
            c.idx        = ClsBksp;
            c.ev.ev_type = EvBksp;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers, synchronous clear and no
// write-to-read bypass.
module key_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A push into a full FIFO is only accepted when the head leaves on the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clear) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrOne;
         if (do_pop)  rptr_d = rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/key_event_queue.sv
// Turns raw PS/2 decoder strobes into one typed event per key press and queues
// them for the consumer FSM behind a valid/ready handshake.
module key_event_queue
   import key_event_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   input  logic [8:0]       last_change,
   input  logic             key_pressed,
   input  logic             flush,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [1:0]       ev_type,
   output logic [3:0]       ev_digit,
   output logic             ev_keypad,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   key_class_t            cls;
   logic [NumClasses-1:0] held_q, held_d;
   logic                  capture;
   logic                  pipe_valid_q, pipe_valid_d;
   key_event_t            pipe_ev_q, pipe_ev_d;
   logic                  overflow_q, overflow_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  drop;
   key_event_t            head;

   assign cls = classify(last_change);

   // A make only counts as a press when the key was not already held down.
   assign capture = key_valid & key_pressed & cls.valid & ~held_q[cls.idx];

   // Flush leaves the held table alone so physically held keys cannot re-fire.
   always_comb begin
      held_d = held_q;
      if (key_valid && cls.valid) held_d[cls.idx] = key_pressed;
   end

   always_comb begin
      pipe_valid_d = capture & ~flush;
      pipe_ev_d    = capture ? cls.ev : pipe_ev_q;
   end

   assign fifo_push = pipe_valid_q & ~flush;
   assign fifo_pop  = ~fifo_empty & ev_ready;
   assign drop      = fifo_push & fifo_full & ~ev_ready;

   always_comb begin
      overflow_d = flush ? 1'b0 : (overflow_q | drop);
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CntOne;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q       <= '0;
         pipe_valid_q <= 1'b0;
         pipe_ev_q    <= '0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         held_q       <= held_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_ev_q    <= pipe_ev_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   key_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EventW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (fifo_push),
      .wdata (pipe_ev_q),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Payload is forced to zero when empty so stale storage never shows up.
   always_comb begin
      ev_valid  = ~fifo_empty;
      ev_type   = ev_valid ? head.ev_type : 2'd0;
      ev_digit  = ev_valid ? head.digit   : 4'd0;
      ev_keypad = ev_valid ? head.keypad  : 1'b0;
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: classification table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_key_event_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             key_valid = 1'b0;
   logic [8:0]       last_change = '0;
   logic             key_pressed = 1'b0;
   logic             flush = 1'b0;
   logic             ev_ready = 1'b0;
   logic             ev_valid;
   logic [1:0]       ev_type;
   logic [3:0]       ev_digit;
   logic             ev_keypad;
   logic             overflow;
   logic [CNT_W-1:0] drop_cnt;

   key_event_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .last_change (last_change),
      .key_pressed (key_pressed),
      .flush       (flush),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_type     (ev_type),
      .ev_digit    (ev_digit),
      .ev_keypad   (ev_keypad),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   logic [6:0] popped[$];
   logic [6:0] exp_q[$];

   typedef struct {
      logic [8:0] code;
      logic       exp_v;
      logic [1:0] t;
      logic [3:0] d;
      logic       kp;
   } vec_t;
   vec_t vecs[28];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [6:0] ev(input int t, input int d, input bit kp);
      return {2'(t), 4'(d), kp};
   endfunction

   function automatic logic [6:0] head();
      return {ev_type, ev_digit, ev_keypad};
   endfunction

   // Records any pop that the coming edge will perform.
   task automatic tick();
      if (ev_valid && ev_ready) popped.push_back(head());
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic key(input logic [8:0] code, input logic pr);
      key_valid   = 1'b1;
      last_change = code;
      key_pressed = pr;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic drain_expect(input string name);
      popped.delete();
      ev_ready = 1'b1;
      ticks(DEPTH + 2);
      ev_ready = 1'b0;
      check({name, "_count"}, 32'(popped.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
         check({name, "_order"}, 32'(popped[i]), 32'(exp_q[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_top[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] m_pad[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
   logic [8:0] r_codes[27];
   logic [6:0] mq[$];
   bit         m_pipe_v;
   logic [6:0] m_pipe;
   bit         m_ovf;
   int         m_cnt;
   bit         m_held[256];

   function automatic bit m_classify(input logic [8:0] code, output logic [6:0] e);
      e = '0;
      if (code[8]) return 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (code[7:0] == m_top[i]) begin e = ev(0, i, 0); return 1'b1; end
         if (code[7:0] == m_pad[i]) begin e = ev(0, i, 1); return 1'b1; end
      end
      if (code[7:0] == 8'h29) begin e = ev(1, 0, 0); return 1'b1; end
      if (code[7:0] == 8'h66) begin e = ev(2, 0, 0); return 1'b1; end
      return 1'b0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pipe_v = 0;
      m_pipe = '0;
      m_ovf = 0;
      m_cnt = 0;
      for (int i = 0; i < 256; i++) m_held[i] = 0;
   endtask

   task automatic model_step(input bit kv, input logic [8:0] code, input bit pr, input bit fl,
                             input bit rdy);
      logic [6:0] e;
      bit pop, cv, cap;
      pop = rdy && (mq.size() > 0);
      cv  = kv && m_classify(code, e);
      cap = cv && pr && !m_held[code[7:0]];
      if (cv) m_held[code[7:0]] = pr;
      if (fl) begin
         mq.delete();
         m_pipe_v = 0;
         m_ovf = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_pipe_v) begin
            if (mq.size() >= DEPTH) begin
               m_ovf = 1;
               if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
               mq.push_back(m_pipe);
            end
         end
         m_pipe_v = cap;
         m_pipe = e;
      end
   endtask

   task automatic random_run(input int cycles, input int kv_pct, input int rdy_pct,
                             input int fl_pct);
      for (int c = 0; c < cycles; c++) begin
         bit kv, pr, fl, rdy;
         logic [8:0] code;
         kv   = ($urandom % 100) < kv_pct;
         pr   = $urandom % 2;
         fl   = ($urandom % 100) < fl_pct;
         rdy  = ($urandom % 100) < rdy_pct;
         code = r_codes[$urandom % 27];
         key_valid = kv; last_change = code; key_pressed = pr; flush = fl; ev_ready = rdy;
         model_step(kv, code, pr, fl, rdy);
         tick();
         check("rnd_valid", 32'(ev_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) check("rnd_head", 32'(head()), 32'(mq[0]));
         check("rnd_overflow", 32'(overflow), 32'(m_ovf));
         check("rnd_drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      end
      key_valid = 0; flush = 0; ev_ready = 0;
      popped.delete();
   endtask

   initial begin
      for (int i = 0; i < 10; i++) begin
         r_codes[i]      = {1'b0, m_top[i]};
         r_codes[i + 10] = {1'b0, m_pad[i]};
      end
      r_codes[20] = 9'h029; r_codes[21] = 9'h066; r_codes[22] = 9'h170;
      r_codes[23] = 9'h145; r_codes[24] = 9'h01C; r_codes[25] = 9'h0F0; r_codes[26] = 9'h012;

      vecs[0]  = '{9'h045, 1, 0, 0, 0}; vecs[1]  = '{9'h016, 1, 0, 1, 0};
      vecs[2]  = '{9'h01E, 1, 0, 2, 0}; vecs[3]  = '{9'h026, 1, 0, 3, 0};
      vecs[4]  = '{9'h025, 1, 0, 4, 0}; vecs[5]  = '{9'h02E, 1, 0, 5, 0};
      vecs[6]  = '{9'h036, 1, 0, 6, 0}; vecs[7]  = '{9'h03D, 1, 0, 7, 0};
      vecs[8]  = '{9'h03E, 1, 0, 8, 0}; vecs[9]  = '{9'h046, 1, 0, 9, 0};
      vecs[10] = '{9'h070, 1, 0, 0, 1}; vecs[11] = '{9'h069, 1, 0, 1, 1};
      vecs[12] = '{9'h072, 1, 0, 2, 1}; vecs[13] = '{9'h07A, 1, 0, 3, 1};
      vecs[14] = '{9'h06B, 1, 0, 4, 1}; vecs[15] = '{9'h073, 1, 0, 5, 1};
      vecs[16] = '{9'h074, 1, 0, 6, 1}; vecs[17] = '{9'h06C, 1, 0, 7, 1};
      vecs[18] = '{9'h075, 1, 0, 8, 1}; vecs[19] = '{9'h07D, 1, 0, 9, 1};
      vecs[20] = '{9'h029, 1, 1, 0, 0}; vecs[21] = '{9'h066, 1, 2, 0, 0};
      vecs[22] = '{9'h170, 0, 0, 0, 0}; vecs[23] = '{9'h11E, 0, 0, 0, 0};
      vecs[24] = '{9'h01C, 0, 0, 0, 0}; vecs[25] = '{9'h0F0, 0, 0, 0, 0};
      vecs[26] = '{9'h000, 0, 0, 0, 0}; vecs[27] = '{9'h166, 0, 0, 0, 0};

      #2;
      check("reset_valid", 32'(ev_valid), 0);
      check("reset_overflow", 32'(overflow), 0);
      check("reset_drop_cnt", 32'(drop_cnt), 0);
      check("reset_payload", 32'(head()), 0);
      rst_n = 1'b1;
      tick();

      // 1: latency and single pop
      key(9'h01E, 1);
      check("t1_not_yet", 32'(ev_valid), 0);
      tick();
      check("t1_valid", 32'(ev_valid), 1);
      check("t1_event", 32'(head()), 32'(ev(0, 2, 0)));
      ev_ready = 1; tick(); ev_ready = 0;
      check("t1_popped", 32'(ev_valid), 0);

      // 2: typematic repeats suppressed
      popped.delete();
      ev_ready = 1;
      for (int i = 0; i < 5; i++) key(9'h016, 1);
      key(9'h016, 0);
      key(9'h016, 1);
      ticks(3);
      ev_ready = 0;
      check("t2_count", 32'(popped.size()), 2);
      for (int i = 0; i < popped.size(); i++) check("t2_event", 32'(popped[i]), 32'(ev(0, 1, 0)));

      // 3: overflow with six makes into a four-deep queue
      key(9'h045, 1); key(9'h069, 1); key(9'h029, 1);
      key(9'h066, 1); key(9'h03E, 1); key(9'h07D, 1);
      ticks(2);
      check("t3_overflow", 32'(overflow), 1);
      check("t3_drop_cnt", 32'(drop_cnt), 2);
      exp_q = '{ev(0, 0, 0), ev(0, 1, 1), ev(1, 0, 0), ev(2, 0, 0)};
      drain_expect("t3_drain");
      check("t3_sticky", 32'(overflow), 1);

      // 4: push into full queue with simultaneous pop
      flush = 1; tick(); flush = 0;
      check("t4_flush_ovf", 32'(overflow), 0);
      check("t4_cnt_kept", 32'(drop_cnt), 2);
      key(9'h045, 0); key(9'h069, 0); key(9'h029, 0); key(9'h066, 0); key(9'h03E, 0);
      key(9'h045, 1); key(9'h069, 1); key(9'h029, 1); key(9'h066, 1);
      tick();
      check("t4_head", 32'(head()), 32'(ev(0, 0, 0)));
      key(9'h03E, 1);
      popped.delete();
      ev_ready = 1; tick(); ev_ready = 0;
      check("t4_pop_count", 32'(popped.size()), 1);
      check("t4_no_drop", 32'(drop_cnt), 2);
      check("t4_no_ovf", 32'(overflow), 0);
      exp_q = '{ev(0, 1, 1), ev(1, 0, 0), ev(2, 0, 0), ev(0, 8, 0)};
      drain_expect("t4_drain");

      // 5: flush with a make on the same edge
      key(9'h045, 0); key(9'h069, 0); key(9'h029, 0); key(9'h066, 0);
      key(9'h03E, 0); key(9'h07D, 0);
      key(9'h045, 1); key(9'h069, 1); key(9'h029, 1); key(9'h066, 1);
      tick();
      key(9'h03E, 1);
      tick();
      check("t5_overflow", 32'(overflow), 1);
      check("t5_drop_cnt", 32'(drop_cnt), 3);
      flush = 1; key(9'h07D, 1); flush = 0;
      tick();
      check("t5_flushed", 32'(ev_valid), 0);
      check("t5_ovf_clear", 32'(overflow), 0);
      check("t5_cnt_kept", 32'(drop_cnt), 3);
      key(9'h07D, 1);
      ticks(2);
      check("t5_repeat_none", 32'(ev_valid), 0);
      key(9'h07D, 0); key(9'h07D, 1);
      tick();
      check("t5_refire_valid", 32'(ev_valid), 1);
      check("t5_refire_event", 32'(head()), 32'(ev(0, 9, 1)));
      ev_ready = 1; tick(); ev_ready = 0;
      check("t5_refire_pop", 32'(ev_valid), 0);

      // Classification table
      for (int i = 0; i < 28; i++) begin
         key(vecs[i].code, 0);
         key(vecs[i].code, 1);
         tick();
         check("tbl_valid", 32'(ev_valid), 32'(vecs[i].exp_v));
         if (vecs[i].exp_v)
            check("tbl_event", 32'(head()), 32'({vecs[i].t, vecs[i].d, vecs[i].kp}));
         ev_ready = 1; tick(); ev_ready = 0;
      end
      check("tbl_cnt_kept", 32'(drop_cnt), 3);

      // 6: ignored codes, then async reset mid-queue
      key(9'h045, 1); key(9'h069, 1);
      key(9'h170, 1); key(9'h01C, 1);
      ticks(2);
      check("t6_ignored", 32'(ev_valid), 0);
      key(9'h045, 0); key(9'h069, 0); key(9'h045, 1); key(9'h069, 1);
      tick();
      check("t6_queued", 32'(ev_valid), 1);
      rst_n = 1'b0;
      #2;
      check("t6_rst_valid", 32'(ev_valid), 0);
      check("t6_rst_payload", 32'(head()), 0);
      check("t6_rst_cnt", 32'(drop_cnt), 0);
      check("t6_rst_ovf", 32'(overflow), 0);
      #2;
      rst_n = 1'b1;
      ticks(3);
      check("t6_empty_after", 32'(ev_valid), 0);
      key(9'h045, 1);
      tick();
      check("t6_held_cleared", 32'(head()), 32'(ev(0, 0, 0)));

      // Randomized against the reference model
      do_reset();
      model_reset();
      random_run(2000, 60, 50, 2);
      random_run(2500, 90, 5, 0);
      check("rnd_saturated", 32'(drop_cnt), 32'(CNT_MAX));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
